// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and phase lengths for the status LED arbiter.
//   led_state_e  - arbiter FSM states
//   ON_TICKS / OFF_TICKS / GAP_TICKS - phase lengths in ticks
//   PHASE_W      - width of the per-phase tick counter (must hold GAP_TICKS)
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } led_state_e;

    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 2;
    localparam int GAP_TICKS = 8;
    localparam int PHASE_W   = 4;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing a one-cycle tick every TICK_DIV clk cycles.
//   clk  - system clock
//   rst  - asynchronous active-high reset (already synchronized)
//   clr  - synchronous clear; restarts the count at 0 on the next edge
//   tick - high while the count equals TICK_DIV-1
module led_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decoded from the registered count only, so tick never depends on clr
    // and the FSM can use it to compute clr without a combinational loop.
    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_status_arbiter.sv
// led_status_arbiter: shares one status LED between N_REQ requesters, playing
// each granted requester's code as n blinks (ON/OFF) followed by a GAP, in
// round-robin order.
//   clk       - system clock
//   rst_btn   - asynchronous active-high reset button (synchronized inside)
//   req       - level request per source
//   blink_cnt - per-source blink count, slice i = [i*BLINK_W +: BLINK_W]
//   grant     - one-hot source currently being played, 0 when idle
//   busy      - high while a code is being played
//   LED       - LED drive, active-high
module led_status_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int N_REQ    = 4,
    parameter int BLINK_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_btn,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*BLINK_W-1:0]   blink_cnt,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    output logic                       LED
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // (a + b) mod N_REQ for a < N_REQ and 0 <= b <= N_REQ.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    // Reset synchronizer: asserts immediately, releases 2 edges later.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) rst_sync_q <= 2'b11;
        else         rst_sync_q <= rst_sync_d;
    end

    assign rst = rst_sync_q[1];

    // Round-robin search over eligible sources (request with nonzero count).
    logic [N_REQ-1:0][BLINK_W-1:0] cnt_v;
    logic [N_REQ-1:0]              elig;
    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]              win_idx;
    logic                          found;

    assign cnt_v = blink_cnt;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) elig[i] = req[i] && (cnt_v[i] != '0);
    end

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!found && elig[wrap_add(rr_ptr_q, off)]) begin
                found   = 1'b1;
                win_idx = wrap_add(rr_ptr_q, off);
            end
        end
    end

    // FSM
    led_state_e          state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [BLINK_W-1:0]  rem_q, rem_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                tick;
    logic                tick_clr;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d          = ON;
                    rem_d            = cnt_v[win_idx];
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    rr_ptr_d         = wrap_add(win_idx, 1);
                end
            end
            ON: begin
                if (tick && phase_q == PHASE_W'(ON_TICKS - 1)) begin
                    state_d = OFF;
                    rem_d   = rem_q - BLINK_W'(1);
                end
            end
            OFF: begin
                // rem_q already counts the blink just finished.
                if (tick && phase_q == PHASE_W'(OFF_TICKS - 1))
                    state_d = (rem_q != '0) ? ON : GAP;
            end
            GAP: begin
                if (tick && phase_q == PHASE_W'(GAP_TICKS - 1)) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Restart tick and phase counting on every state entry so each phase
    // is an exact multiple of TICK_DIV cycles.
    assign tick_clr = (state_d != state_q);

    always_comb begin
        phase_d = phase_q;
        if (tick_clr)  phase_d = '0;
        else if (tick) phase_d = phase_q + PHASE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            rem_q    <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            rem_q    <= rem_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);
    assign LED   = (state_q == ON);

endmodule

// File: tb/tb_led_status_arbiter.sv
module tb_led_status_arbiter;

    localparam int TD = 4;
    localparam int NR = 4;
    localparam int BW = 4;

    typedef struct {
        logic [NR-1:0] grant;
        int            len;
        int            blinks;
        int            gap;     // expected idle cycles before this code; 0 = unchecked
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_btn = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*BW-1:0]  blink_cnt = '0;
    logic [NR-1:0]     grant;
    logic              busy;
    logic              LED;

    always #5 clk = ~clk;

    led_status_arbiter #(.TICK_DIV(TD), .N_REQ(NR), .BLINK_W(BW)) dut (
        .clk       (clk),
        .rst_btn   (rst_btn),
        .req       (req),
        .blink_cnt (blink_cnt),
        .grant     (grant),
        .busy      (busy),
        .LED       (LED)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [NR-1:0] g, input int n, input int gap);
        exp_t e;
        e.grant  = g;
        e.len    = (4 * n + 8) * TD;
        e.blinks = n;
        e.gap    = gap;
        return e;
    endfunction

    exp_t exp_q[$];

    // Monitor: pops an expected code when busy rises, checks its shape when busy falls.
    bit            mon_en = 1'b1;
    bit            have_cur = 1'b0;
    exp_t          cur;
    logic          prev_busy = 1'b0, prev_led = 1'b0;
    logic [NR-1:0] g0;
    int bcnt, rises, run, since_fall, idle_cnt;
    bit gchg;

    always @(negedge clk) begin
        if (!mon_en) begin
            have_cur = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexp_grant", 32'(grant), 0);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("grant", 32'(grant), 32'(cur.grant));
                    check("led_on_at_grant", 32'(LED), 1);
                    if (cur.gap != 0) check("idle_gap", idle_cnt, cur.gap);
                end
                bcnt = 0; rises = 0; run = 0; since_fall = 0; gchg = 1'b0; g0 = grant;
            end
            if (busy) begin
                bcnt++;
                if (grant !== g0) gchg = 1'b1;
                if (LED) begin
                    if (!prev_led) rises++;
                    run++;
                    since_fall = 0;
                end else begin
                    if (prev_led && have_cur) check("on_len", run, 2 * TD);
                    run = 0;
                    since_fall++;
                end
            end
            if (!busy && prev_busy) begin
                if (have_cur) begin
                    check("busy_len", bcnt, cur.len);
                    check("blinks", rises, cur.blinks);
                    check("tail_low", since_fall, 10 * TD);
                    check("grant_stable", 32'(gchg), 0);
                end
                have_cur = 1'b0;
                idle_cnt = 0;
            end
            if (!busy) idle_cnt++;
        end
        prev_busy = busy;
        prev_led  = LED;
    end

    // Hold reset for two edges, apply the new inputs, release between edges.
    task automatic pulse_reset(input logic [NR-1:0] r, input logic [NR*BW-1:0] c);
        rst_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req       = r;
        blink_cnt = c;
        @(negedge clk);
        rst_btn = 1'b0;
    endtask

    // Wait until every queued code has started, then withdraw/alter the
    // request mid-code, let the code finish and watch for stray grants.
    task automatic finish_flow();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("timeout_start", 1, 0);
        @(posedge clk); #1;
        req       = '0;
        blink_cnt = 16'h5555;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) check("timeout_busy", 1, 0);
        repeat (100) @(posedge clk);
        #1;
    endtask

    initial begin
        int  edges;
        bit  ok;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_led",   32'(LED), 0);

        // Single request, code 3, repeats back-to-back
        req       = 4'b0001;
        blink_cnt = 16'h0003;
        exp_q.push_back(mk(4'b0001, 3, 0));
        exp_q.push_back(mk(4'b0001, 3, 1));
        @(negedge clk);
        rst_btn = 1'b0;
        finish_flow();

        // Round-robin across all four
        exp_q.push_back(mk(4'b0001, 1, 0));
        exp_q.push_back(mk(4'b0010, 1, 1));
        exp_q.push_back(mk(4'b0100, 1, 1));
        exp_q.push_back(mk(4'b1000, 1, 1));
        exp_q.push_back(mk(4'b0001, 1, 1));
        pulse_reset(4'b1111, 16'h1111);
        finish_flow();

        // Zero count on source 0 is never granted
        exp_q.push_back(mk(4'b0010, 2, 0));
        exp_q.push_back(mk(4'b0010, 2, 1));
        pulse_reset(4'b0011, 16'h0020);
        finish_flow();

        // Mid-code changes ignored (req drops, count becomes 5 during ON)
        exp_q.push_back(mk(4'b0001, 2, 0));
        pulse_reset(4'b0001, 16'h0002);
        finish_flow();

        // Maximum count
        exp_q.push_back(mk(4'b1000, 15, 0));
        pulse_reset(4'b1000, 16'hF000);
        finish_flow();

        // Reset during OFF clears outputs without a clock edge
        mon_en = 1'b0;
        pulse_reset(4'b0001, 16'h0002);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) begin ok = 1'b1; break; end
        end
        if (!ok) check("timeout_s5", 1, 0);
        repeat (10) @(posedge clk);
        #1;
        check("off_led",   32'(LED), 0);
        check("off_busy",  32'(busy), 1);
        check("off_grant", 32'(grant), 1);
        #2;
        rst_btn = 1'b1;
        #1;
        check("async_led",   32'(LED), 0);
        check("async_grant", 32'(grant), 0);
        check("async_busy",  32'(busy), 0);
        req       = 4'b0100;
        blink_cnt = 16'h0100;
        exp_q.push_back(mk(4'b0100, 1, 0));
        mon_en = 1'b1;
        @(negedge clk);
        rst_btn = 1'b0;
        edges = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (grant != '0) begin edges = e; break; end
        end
        check("rst_lat_min", 32'(edges >= 3), 1);
        check("grant_after_rst", 32'(grant), 32'(4'b0100));
        finish_flow();

        // rr_ptr is now 3; after reset the search must start at 0 again
        exp_q.push_back(mk(4'b0010, 1, 0));
        pulse_reset(4'b1010, 16'h1010);
        finish_flow();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_status_arbiter.md
# led_status_arbiter

Shares the board's single status LED between up to N_REQ requesters, each of which blinks a numeric code. The arbiter grants one requester at a time in round-robin order. It plays that requester's code as n blinks followed by an inter-code gap, then re-arbitrates. The block sits between the system status sources and the LED pin, and replaces the free-running 1 Hz blinker as the LED driver.

## Interface
- TICK_DIV, 12_500_000: clk cycles per tick (125 ms at 100 MHz); must be ≥ 2.
- N_REQ, 4: number of requesters, 2..8.
- BLINK_W, 4: width of each blink count.
- clk  in  1  system clock.
- rst_btn  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  level request per source; synchronous to clk.
- blink_cnt  in  N_REQ*BLINK_W  code per source; slice i is bits [i*BLINK_W +: BLINK_W].
- grant  out  N_REQ  one-hot index of the source being played; 0 when idle.
- busy  out  1  high while a code is being played.
- LED  out  1  LED drive, active-high.

## Operation
- Reset: rst_btn passes through a 2-FF synchronizer.
  - Assertion is asynchronous.
  - Deassertion is synchronous, 2 clk edges after rst_btn falls.
  - The synchronized rst asynchronously clears all other state.
- Reset values: LED=0, grant=0, busy=0, state=IDLE, rr_ptr=0, tick counter=0.
- Tick generator counts 0..TICK_DIV-1 and pulses tick for one cycle when the count equals TICK_DIV-1.
  - It is cleared synchronously by the FSM on every state entry, so each phase lasts exactly k*TICK_DIV cycles.
- Eligible source i: req[i]=1 and blink_cnt slice i ≠ 0. A source with a zero count is never granted.
- Arbitration happens in IDLE only.
  - Search starts at rr_ptr, ascends and wraps; the first eligible source wins.
  - Its count is latched into the remaining-blinks counter.
  - rr_ptr becomes (winner+1) mod N_REQ.
- FSM states:
  - IDLE: LED=0, busy=0, grant=0. Goes to ON if any source is eligible.
  - ON: LED=1. After ON_TICKS=2 ticks goes to OFF and decrements remaining.
  - OFF: LED=0. After OFF_TICKS=2 ticks, goes to ON if remaining≠0, else to GAP.
  - GAP: LED=0. After GAP_TICKS=8 ticks goes to IDLE.
- busy and grant hold constant from leaving IDLE to re-entering IDLE.
- Changes to req or blink_cnt during a sequence are ignored; the current code always completes.
- Reset mid-sequence aborts the code immediately. After reset, arbitration restarts from source 0.

## Timing
- Grant latency: an eligible request present at rising edge k (state IDLE) gives grant, busy and LED=1 after edge k.
- Code of n blinks: busy high for (4n+8)*TICK_DIV cycles, then exactly 1 IDLE cycle before the next grant.
- Back-to-back requesters therefore see a 1-cycle busy gap.
- After rst_btn release, the first grant occurs no earlier than the 3rd rising edge.
- Widths:
  - tick counter: $clog2(TICK_DIV) bits
  - phase counter: 4 bits (max 8)
  - remaining-blinks counter: BLINK_W bits
  - rr_ptr: $clog2(N_REQ) bits
- Maximum count 2^BLINK_W-1 plays fully with no wrap.

## Structure
- Package led_ctrl_pkg holds:
  - the state enum {IDLE, ON, OFF, GAP}
  - constants ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=8
- Sub-module led_tick_gen: TICK_DIV prescaler with synchronous clear input and tick output.
- The reset synchronizer, round-robin search and FSM live in the top level.

## Test plan
All scenarios use TICK_DIV=4, N_REQ=4, BLINK_W=4.
- Single request: req=0001, cnt0=3 → grant=0001 and busy=1 for 80 cycles. LED is high 8, low 8, repeated 3 times, then low 32. IDLE for 1 cycle, then the code restarts.
- Round-robin: req=1111, all counts=1 → grants 0001, 0010, 0100, 1000, 0001, each lasting 48 cycles with a 1-cycle gap between them.
- Zero count: req=0011, cnt0=0, cnt1=2 → only grant=0010 ever issues; each code lasts 64 cycles.
- Mid-code changes: req drops and cnt changes from 2 to 5 during ON of the first blink → still exactly 2 blinks, then IDLE with no further grant.
- Reset mid-sequence: rst_btn pulsed during OFF → LED, grant and busy go to 0 without waiting for a clk edge. After release with req=0100, grant=0100 appears at the 3rd rising edge or later, and rr_ptr has restarted at 0.
- Maximum count: cnt=15 on source 3 only → 15 blinks, busy for 272 cycles, no counter wrap.
